// File: rtl/clk_rst_seq.sv
// Reset/clock bring-up sequencer on the reference clock: debounces the reset switch,
// pulses the DCM reset, waits for stable lock and releases chip_reset. Define LOCK_LOSS_CNT_EN for lock_loss_cnt.
module clk_rst_seq #(
  parameter logic [15:0] DEBOUNCE_CNT   = 16'd1000,
  parameter logic [15:0] DCM_RST_CYCLES = 16'd4,
  parameter logic [15:0] LOCK_TIMEOUT   = 16'd50000,
  parameter logic [15:0] RELEASE_DELAY  = 16'd256,
  parameter logic [3:0]  MAX_RETRY      = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_sw,
  input  logic       locked,
  output logic       dcm_reset,
  output logic       chip_reset,
  output logic [2:0] seq_state,
  output logic       fail,
  output logic [3:0] retry_cnt
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_DCM_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_db_cnt;
  logic        r_sw_meta, r_sw_s, r_lk_meta, r_lk_s, r_sw_db;
  logic        r_dcm_reset, r_chip_reset, r_fail;
  logic [3:0]  r_retry_cnt;
  logic        w_db_flip, w_db_next, w_force;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_meta <= 1'b1;
      r_sw_s    <= 1'b1;
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_sw_meta <= reset_sw;
      r_sw_s    <= r_sw_meta;
      r_lk_meta <= locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  assign w_db_flip = (r_sw_s != r_sw_db) && (r_db_cnt == DEBOUNCE_CNT - 16'd1);
  assign w_db_next = w_db_flip ? r_sw_s : r_sw_db;
  // Force covers the press edge itself and the release edge, so the restart pulse is full width.
  assign w_force   = !r_sw_db || !w_db_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_db  <= 1'b1;
      r_db_cnt <= 16'd0;
    end else if (r_sw_s == r_sw_db || w_db_flip) begin
      r_sw_db  <= w_db_next;
      r_db_cnt <= 16'd0;
    end else begin
      r_db_cnt <= r_db_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_DCM_RST;
      r_cnt        <= 16'd0;
      r_dcm_reset  <= 1'b1;
      r_chip_reset <= 1'b0;
      r_fail       <= 1'b0;
      r_retry_cnt  <= 4'd0;
    end else if (w_force) begin
      r_state      <= ST_DCM_RST;
      r_cnt        <= 16'd0;
      r_dcm_reset  <= 1'b1;
      r_chip_reset <= 1'b0;
      r_fail       <= 1'b0;
      r_retry_cnt  <= 4'd0;
    end else begin
      case (r_state)
        ST_DCM_RST: begin
          r_dcm_reset  <= 1'b1;
          r_chip_reset <= 1'b0;
          if (r_cnt == DCM_RST_CYCLES - 16'd1) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= 16'd0;
            r_dcm_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lk_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= 16'd0;
          end else if (r_cnt == LOCK_TIMEOUT - 16'd1) begin
            r_cnt <= 16'd0;
            if (r_retry_cnt + 4'd1 == MAX_RETRY) begin
              r_state     <= ST_FAIL;
              r_retry_cnt <= MAX_RETRY;
              r_fail      <= 1'b1;
            end else begin
              r_state     <= ST_DCM_RST;
              r_retry_cnt <= r_retry_cnt + 4'd1;
              r_dcm_reset <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STABLE: begin
          if (!r_lk_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= 16'd0;
          end else if (r_cnt == RELEASE_DELAY - 16'd1) begin
            r_state      <= ST_RUN;
            r_cnt        <= 16'd0;
            r_chip_reset <= 1'b1;
            r_retry_cnt  <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          r_chip_reset <= 1'b1;
          if (!r_lk_s) begin
            r_state      <= ST_DCM_RST;
            r_cnt        <= 16'd0;
            r_chip_reset <= 1'b0;
            r_dcm_reset  <= 1'b1;
          end
        end
        ST_FAIL: begin
          r_dcm_reset  <= 1'b0;
          r_chip_reset <= 1'b0;
          r_fail       <= 1'b1;
        end
        default: begin
          r_state      <= ST_DCM_RST;
          r_cnt        <= 16'd0;
          r_dcm_reset  <= 1'b1;
          r_chip_reset <= 1'b0;
        end
      endcase
    end
  end

  assign dcm_reset  = r_dcm_reset;
  assign chip_reset = r_chip_reset;
  assign seq_state  = r_state;
  assign fail       = r_fail;
  assign retry_cnt  = r_retry_cnt;

`ifdef LOCK_LOSS_CNT_EN
  // Survives switch presses on purpose; only the power-on reset clears it.
  logic [7:0] r_lock_loss_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_lock_loss_cnt <= 8'd0;
    else if (!w_force && r_state == ST_RUN && !r_lk_s && r_lock_loss_cnt != 8'hFF)
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
  end
  assign lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule
